// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port (core / host) arbiter in front of a single-port data
//            memory. Round-robin under contention, optional host burst lock
//            bounded by MAX_BURST, one-cycle read-data return per requester.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter must be able to hold MAX_BURST itself (saturation value).
    localparam int            CW          = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);

    // Owner of the most recent granted access.
    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CORE = 2'd1;
    localparam logic [1:0] OWNER_HOST = 2'd2;

    logic [1:0]    last_owner;
    logic [CW-1:0] burst_cnt;
    logic          pick_core;
    logic          pick_host;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] wdata_hold;
    logic [DW-1:0] core_rdata_hold;
    logic [DW-1:0] host_rdata_hold;

    // Arbitration decision: single requester wins outright; under contention
    // the starvation bound beats the lock, the lock beats round-robin.
    always_comb begin
        pick_core = 1'b0;
        pick_host = 1'b0;
        if (core_req && host_req) begin
            if (burst_cnt == BURST_LIMIT) begin
                pick_core = 1'b1;
            end else if (host_lock && (last_owner == OWNER_HOST)) begin
                pick_host = 1'b1;
            end else if (last_owner == OWNER_CORE) begin
                pick_host = 1'b1;
            end else begin
                pick_core = 1'b1;
            end
        end else if (core_req) begin
            pick_core = 1'b1;
        end else if (host_req) begin
            pick_host = 1'b1;
        end
    end

    // Grants are combinational, so they are masked directly by the
    // asynchronous reset to drop the instant reset asserts.
    assign core_gnt = reset & pick_core;
    assign host_gnt = reset & pick_host;

    // Memory port mirrors the winner; address/data hold when idle. The hold
    // registers clear asynchronously, which also zeroes mem_addr/mem_wdata
    // in reset because no grant can be active then.
    always_comb begin
        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Ownership, burst counting and last-driven memory address/data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWNER_NONE;
            burst_cnt  <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold  <= mem_addr;
            wdata_hold <= mem_wdata;
            if (core_gnt) begin
                last_owner <= OWNER_CORE;
            end else if (host_gnt) begin
                last_owner <= OWNER_HOST;
            end
            // Only host grants that keep a waiting core out are counted.
            if (core_gnt || !core_req) begin
                burst_cnt <= '0;
            end else if (host_gnt && (burst_cnt != BURST_LIMIT)) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end
    end

    // Read-valid pipeline: one cycle after a granted read; writes never
    // produce a valid. Reset kills any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            core_rvalid <= core_gnt & ~core_we;
            host_rvalid <= host_gnt & ~host_we;
        end
    end

    // Capture returned data so each rdata port holds its last valid word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_rdata_hold <= '0;
            host_rdata_hold <= '0;
        end else begin
            if (core_rvalid) begin
                core_rdata_hold <= mem_rdata;
            end
            if (host_rvalid) begin
                host_rdata_hold <= mem_rdata;
            end
        end
    end

    // Memory data is presented live in the valid cycle, held otherwise.
    assign core_rdata = core_rvalid ? mem_rdata : core_rdata_hold;
    assign host_rdata = host_rvalid ? mem_rdata : host_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A behavioural memory sits
//            on the mem_* port; a reference model derived from the
//            arbitration rules predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;
    localparam int VW        = 4 + 2 * AW + 2 + 3 * DW - AW; // 38 bits

    localparam int NONE = 0;
    localparam int CORE = 1;
    localparam int HOST = 2;

    logic          clk;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req, host_we, host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp;
    int n_fail;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_lock  (host_lock),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment memory: single port, registered read.
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [256];
    int            m_last;
    int            m_burst;
    logic [AW-1:0] m_addr_hold;
    logic [DW-1:0] m_wdata_hold;
    logic          m_crv, m_hrv;
    logic [DW-1:0] m_crd, m_hrd;
    int            e_win;
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_reset();
        m_last       = NONE;
        m_burst      = 0;
        m_addr_hold  = '0;
        m_wdata_hold = '0;
        m_crv        = 1'b0;
        m_hrv        = 1'b0;
        m_crd        = '0;
        m_hrd        = '0;
        e_win        = NONE;
        e_en         = 1'b0;
        e_we         = 1'b0;
        e_addr       = '0;
        e_wdata      = '0;
    endtask

    // Who should win this cycle, and what the memory port should show.
    task automatic model_eval();
        if (core_req && host_req) begin
            if (m_burst >= MAX_BURST)                 e_win = CORE;
            else if (host_lock && m_last == HOST)     e_win = HOST;
            else                                      e_win = (m_last == CORE) ? HOST : CORE;
        end else if (core_req) e_win = CORE;
        else if (host_req)     e_win = HOST;
        else                   e_win = NONE;
        e_en    = (e_win != NONE);
        e_we    = (e_win == CORE) ? core_we    : (e_win == HOST) ? host_we    : 1'b0;
        e_addr  = (e_win == CORE) ? core_addr  : (e_win == HOST) ? host_addr  : m_addr_hold;
        e_wdata = (e_win == CORE) ? core_wdata : (e_win == HOST) ? host_wdata : m_wdata_hold;
    endtask

    // Consequences of the cycle that just ended at a rising edge.
    task automatic model_commit();
        m_crv = 1'b0;
        m_hrv = 1'b0;
        if (e_win == CORE && !e_we) begin m_crv = 1'b1; m_crd = m_mem[e_addr]; end
        if (e_win == HOST && !e_we) begin m_hrv = 1'b1; m_hrd = m_mem[e_addr]; end
        if (e_en && e_we) m_mem[e_addr] = e_wdata;
        if (e_win == CORE || !core_req) m_burst = 0;
        else if (e_win == HOST)         m_burst = (m_burst < MAX_BURST) ? m_burst + 1 : MAX_BURST;
        if (e_win != NONE) m_last = e_win;
        m_addr_hold  = e_addr;
        m_wdata_hold = e_wdata;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {core_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                core_rvalid, host_rvalid, core_rdata, host_rdata};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {(e_win == CORE), (e_win == HOST), e_en, e_we, e_addr, e_wdata,
                m_crv, m_hrv, m_crd, m_hrd};
    endfunction

    // One clock cycle: commit the previous cycle, drive, settle at negedge.
    task automatic apply(input logic cr, input logic cw, input logic [AW-1:0] ca,
                         input logic [DW-1:0] cd, input logic hr, input logic hw,
                         input logic hl, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk);
        model_commit();
        #1;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_lock = hl; host_addr = ha; host_wdata = hd;
        @(negedge clk);
        model_eval();
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, core_addr, core_wdata, 1'b0, 1'b0, 1'b0, host_addr, host_wdata);
    endtask

    task automatic release_reset();
        core_req  = 1'b0;
        host_req  = 1'b0;
        host_lock = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h11; core_wdata = 8'h22;
        host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1; host_addr = 8'h33; host_wdata = 8'h44;
        model_reset();
        #13;
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
        end
        release_reset();
    endtask

    task automatic test_host_load();
        logic [AW-1:0] adr [5];
        logic [DW-1:0] dat [5];
        adr = '{8'd0, 8'd1, 8'd6, 8'd7, 8'd6};
        dat = '{8'hF0, 8'h01, 8'hAA, 8'h55, 8'h00};
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, (i < 4), 1'b0, adr[i], dat[i]);
            n_cmp++;
            if (host_gnt !== 1'b1 || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL host_load[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
        n_cmp++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'hAA || core_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL host_load_read: got rvalid=%b rdata=%h want rvalid=1 rdata=aa",
                     host_rvalid, host_rdata);
        end
        idle();
        n_cmp++;
        if (host_rvalid !== 1'b0 || host_rdata !== 8'hAA) begin
            n_fail++;
            $display("FAIL host_rdata_hold: got rvalid=%b rdata=%h want rvalid=0 rdata=aa",
                     host_rvalid, host_rdata);
        end
    endtask

    task automatic test_round_robin();
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b0, 8'd6, 8'h00, 1'b1, 1'b0, 1'b0, 8'd7, 8'h00);
            n_cmp++;
            if (core_gnt !== (i % 2 == 0) || host_gnt !== (i % 2 == 1) || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
        n_cmp++;
        if (host_rvalid !== 1'b1 || core_rvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL round_robin_tail: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_lock();
        logic exp_host [7];
        exp_host = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        apply(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'd20, 8'h00);
        n_cmp++;
        if (host_gnt !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL lock_setup: got %h want %h", obs_vec(), exp_vec());
        end
        for (int i = 0; i < 7; i++) begin
            apply(1'b1, 1'b0, 8'd30, 8'h00, 1'b1, 1'b1, (i < 5), 8'(21 + i), 8'(8'h90 + i));
            n_cmp++;
            if (host_gnt !== exp_host[i] || core_gnt !== !exp_host[i] || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lock_burst[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
    endtask

    task automatic test_raw();
        apply(1'b1, 1'b1, 8'd3, 8'h03, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00);
        apply(1'b0, 1'b0, 8'd3, 8'h03, 1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
        n_cmp++;
        if (host_gnt !== 1'b1 || core_rvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL raw_grant: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
        n_cmp++;
        if (host_rvalid !== 1'b1 || host_rdata !== 8'h03) begin
            n_fail++;
            $display("FAIL raw_data: got rvalid=%b rdata=%h want rvalid=1 rdata=03",
                     host_rvalid, host_rdata);
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'd40, 8'h00);
        apply(1'b1, 1'b0, 8'd41, 8'h00, 1'b1, 1'b0, 1'b1, 8'd42, 8'h00);
        #1 reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec() !== '0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_async: got %h want %h", obs_vec(), exp_vec());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (core_rvalid !== 1'b0 || host_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got crv=%b hrv=%b en=%b want 0 0 0",
                     core_rvalid, host_rvalid, mem_en);
        end
        release_reset();
        apply(1'b1, 1'b0, 8'd43, 8'h00, 1'b1, 1'b0, 1'b0, 8'd44, 8'h00);
        n_cmp++;
        if (core_gnt !== 1'b1 || host_rvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %h want %h", obs_vec(), exp_vec());
        end
        apply(1'b0, 1'b0, 8'd43, 8'h00, 1'b1, 1'b0, 1'b0, 8'd44, 8'h00);
        idle();
    endtask

    task automatic test_idle();
        apply(1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'd9, 8'h5C);
        for (int i = 0; i < 3; i++) begin
            idle();
            n_cmp++;
            if (mem_en !== 1'b0 || mem_addr !== 8'd9 || mem_wdata !== 8'h5C || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        apply(1'b1, 1'b0, 8'd10, 8'h00, 1'b1, 1'b0, 1'b0, 8'd11, 8'h00);
        n_cmp++;
        if (core_gnt !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL idle_then_core: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
        idle();
        apply(1'b1, 1'b0, 8'd12, 8'h00, 1'b1, 1'b0, 1'b0, 8'd11, 8'h00);
        n_cmp++;
        if (host_gnt !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL idle_then_host: got %h want %h", obs_vec(), exp_vec());
        end
        idle();
    endtask

    task automatic test_random();
        logic          cr, cw, hr, hw, hl;
        logic [AW-1:0] ca, ha;
        logic [DW-1:0] cd, hd;
        cr = 1'b0; cw = 1'b0; hr = 1'b0; hw = 1'b0;
        ca = '0; ha = '0; cd = '0; hd = '0;
        for (int i = 0; i < 400; i++) begin
            // A requester keeps its request frozen until it is granted.
            if (!(cr && e_win != CORE)) begin
                cr = ($urandom_range(0, 9) < 7);
                cw = $urandom_range(0, 1) == 1;
                ca = 8'($urandom_range(0, 15));
                cd = 8'($urandom);
            end
            if (!(hr && e_win != HOST)) begin
                hr = ($urandom_range(0, 9) < 7);
                hw = $urandom_range(0, 1) == 1;
                ha = 8'($urandom_range(0, 15));
                hd = 8'($urandom);
            end
            hl = ($urandom_range(0, 9) < 6);
            apply(cr, cw, ca, cd, hr, hw, hl, ha, hd);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        idle();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_tail: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int a = 0; a < 256; a++) begin
            ram[a]   = 8'($urandom);
            m_mem[a] = ram[a];
        end
        test_reset();
        test_host_load();
        test_round_robin();
        test_lock();
        test_raw();
        test_reset_mid();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have parameter AW, default 8, meaning the data-memory address width in bits.
REQ-002 The module SHALL have parameter DW, default 8, meaning the data-memory word width in bits.
REQ-003 The module SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive locked host grants while the core is waiting.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 Port core_req / core_we, input, 1 bit each: core access request and write enable.
REQ-007 Port core_addr, input, AW bits, and port core_wdata, input, DW bits: core address and write data.
REQ-008 Port core_gnt / core_rvalid, output, 1 bit each: core access accepted this cycle, and core read data valid.
REQ-009 Port core_rdata, output, DW bits: core read data.
REQ-010 Port host_req / host_we / host_lock, input, 1 bit each: host (loader/bench) request, write enable, and burst lock.
REQ-011 Port host_addr, input, AW bits, and port host_wdata, input, DW bits: host address and write data.
REQ-012 Port host_gnt / host_rvalid, output, 1 bit each, and port host_rdata, output, DW bits: host grant, read-data valid and read data.
REQ-013 Port mem_en / mem_we, output, 1 bit each: memory access strobe and memory write enable.
REQ-014 Port mem_addr, output, AW bits, and port mem_wdata, output, DW bits: memory address and write data.
REQ-015 Port mem_rdata, input, DW bits: memory read data, valid one cycle after a read strobe.

Function
REQ-016 The arbiter SHALL grant at most one requester per cycle; grant is combinational from req and registered state; mem_* SHALL mirror the winner's signals in the same cycle.
REQ-017 No request: mem_en=0, both gnt=0, mem_addr/mem_wdata SHALL hold the last driven value.
REQ-018 State register last_owner in {NONE, CORE, HOST}; updates each granted cycle to the winner, unchanged on idle cycles.
REQ-019 Single requester SHALL be granted immediately.
REQ-020 Both requesting, no lock: round-robin; the requester that is not last_owner wins; if last_owner=NONE, core wins.
REQ-021 Both requesting, host_lock=1, last_owner=HOST: host SHALL keep the grant while burst_cnt < MAX_BURST.
REQ-022 burst_cnt SHALL count consecutive host grants while core_req=1, clear on any core grant or when core_req=0, and saturate at MAX_BURST.
REQ-023 When burst_cnt = MAX_BURST and core_req=1, the core SHALL be granted regardless of host_lock (starvation bound).
REQ-024 A granted read (gnt=1, we=0) SHALL assert that requester's rvalid exactly one cycle later, with rdata = mem_rdata; the other rvalid stays 0.
REQ-025 Writes SHALL produce no rvalid; read-after-write to the same address by either requester in consecutive cycles SHALL return the new data (memory write-first).
REQ-026 core_rdata/host_rdata SHALL hold their last valid value when rvalid=0.
REQ-027 Requesters SHALL hold req, we, addr and wdata stable until gnt; the arbiter SHALL NOT buffer requests.

Reset
REQ-028 reset=0 SHALL immediately force: gnt, rvalid, mem_en and mem_we = 0; mem_addr, mem_wdata, core_rdata and host_rdata = 0; last_owner = NONE; burst_cnt = 0.
REQ-029 A read granted in the cycle reset asserts SHALL NOT produce an rvalid after reset release.
REQ-030 The first grant SHALL be possible in the first rising edge cycle after reset deasserts.

Verification
REQ-031 Host-only writes 0xF0→addr0, 0x01→addr1, 0xAA→addr6, 0x55→addr7, then host reads addr6 -> host_gnt each cycle; host_rvalid one cycle after the read; host_rdata=0xAA.
REQ-032 Core and host both read every cycle, no lock, starting from reset -> grants alternate core, host, core, host; each rvalid goes to the correct side one cycle later.
REQ-033 host_lock=1 with both requesting continuously -> host granted 4 consecutive cycles, core on the 5th, then round-robin resumes.
REQ-034 Core writes 0x03→addr3, host reads addr3 next cycle -> host_rdata=0x03.
REQ-035 reset pulled low mid-burst with a pending read -> all outputs 0 asynchronously; no rvalid after release; first post-reset contention grants core.
REQ-036 Idle cycles between grants -> mem_en=0, last_owner and mem_addr hold; the next contention follows REQ-020 from the held last_owner.
